// File: rtl/exec_trace_buffer_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared constants and types for the execution trace buffer that watches the
// single-cycle MIPS core.
//   - traceState_e : capture FSM states (IDLE/ARMED/POST/FROZEN)
//   - DEPTH/AW     : ring size and pointer width
//   - ENTRY_W      : stored word width, 64 bits or 64+TS_W bits
//   - *_LSB        : bit offsets of each field inside a stored entry
//   - clampPost    : limits the post-trigger sample count to DEPTH-1
// Optional feature macro: TRACE_TIMESTAMP_EN. When it is defined, every entry
// also carries a TS_W-bit cycle timestamp in its top bits.
// ---------------------------------------------------------------------------
package trace_pkg;

   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);
   localparam int TS_W  = 16;

   localparam int ALU_LSB   = 0;
   localparam int INSTR_LSB = 32;
`ifdef TRACE_TIMESTAMP_EN
   localparam int TS_LSB  = 64;
   localparam int ENTRY_W = 64 + TS_W;
`else
   localparam int ENTRY_W = 64;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } traceState_e;

   // A window can never hold more than DEPTH-1 samples after the trigger.
   // If it could, the trigger sample itself would be overwritten.
   function automatic logic [AW-1:0] clampPost(input logic [AW-1:0] postCount);
      logic [AW-1:0] limit;
      limit = AW'(DEPTH - 1);
      return (postCount > limit) ? limit : postCount;
   endfunction

endpackage

// File: rtl/exec_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// exec_trace_buffer_if
// This interface groups the sample, control, read and status signals of the
// trace buffer.
//   - master : the debug host / core side. It drives the samples, the
//              controls and rd_ready, and it observes the status.
//   - slave  : the trace buffer itself.
// Signals:
//   - smp_valid/smp_instr/smp_alu   : one core sample per cycle when valid
//   - arm/abort                     : capture control pulses
//   - trig_mask/trig_match          : instruction trigger compare
//   - post_count                    : samples kept after the trigger
//   - rd_valid/rd_ready/rd_data     : in-order drain port
//   - state/count/triggered         : status
// Optional feature macro: TRACE_TIMESTAMP_EN. It widens rd_data through
// ENTRY_W.
// ---------------------------------------------------------------------------
interface exec_trace_buffer_if import trace_pkg::*; ();

   logic               smp_valid;
   logic [31:0]        smp_instr;
   logic [31:0]        smp_alu;
   logic               arm;
   logic               abort;
   logic [31:0]        trig_mask;
   logic [31:0]        trig_match;
   logic [AW-1:0]      post_count;
   logic               rd_valid;
   logic               rd_ready;
   logic [ENTRY_W-1:0] rd_data;
   logic [1:0]         state;
   logic [AW:0]        count;
   logic               triggered;

   modport master (
      output smp_valid, smp_instr, smp_alu, arm, abort,
             trig_mask, trig_match, post_count, rd_ready,
      input  rd_valid, rd_data, state, count, triggered
   );

   modport slave (
      input  smp_valid, smp_instr, smp_alu, arm, abort,
             trig_mask, trig_match, post_count, rd_ready,
      output rd_valid, rd_data, state, count, triggered
   );

endinterface

// File: rtl/exec_trace_buffer_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
// This is the storage array behind the trace ring: DEPTH x W bits.
// Writes are synchronous on clock. Reads are asynchronous.
// The array has no reset, because its contents are only ever shown through a
// valid-gated read path.
//   - clock    : write clock
//   - we_i     : write enable
//   - wAddr_i  : write address
//   - wData_i  : write data
//   - rAddr_i  : read address
//   - rData_o  : combinational read data
// No configuration macros are used here. The width comes from the parent.
// ---------------------------------------------------------------------------
module trace_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int W     = 64
) (
   input  logic          clock,
   input  logic          we_i,
   input  logic [AW-1:0] wAddr_i,
   input  logic [W-1:0]  wData_i,
   input  logic [AW-1:0] rAddr_i,
   output logic [W-1:0]  rData_o
);

   logic [W-1:0] mem [DEPTH];

   // Plain write port. The capture FSM makes sure only live samples reach it.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem[wAddr_i] <= wData_i;
      end
   end

   assign rData_o = mem[rAddr_i];

endmodule

// File: rtl/exec_trace_buffer.sv
// ---------------------------------------------------------------------------
// exec_trace_buffer
// This is a logic-analyser style trace capture block for the single-cycle
// MIPS core.
// It records {instr, alu} samples into a ring buffer while armed.
// It freezes a window around the first instruction that matches the trigger,
// then drains that window oldest-first over a valid/ready port.
//   - clock : single clock
//   - reset : asynchronous, active-high, clears all state
//   - bus   : exec_trace_buffer_if.slave (samples, controls, read port, status)
// Optional feature macro: TRACE_TIMESTAMP_EN.
//   - When defined, a free-running TS_W-bit cycle counter is prepended to
//     every stored entry.
//   - When undefined, entries are {instr, alu}.
// ---------------------------------------------------------------------------
module exec_trace_buffer import trace_pkg::*; (
   input logic                 clock,
   input logic                 reset,
   exec_trace_buffer_if.slave  bus
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

   traceState_e        state_q, state_d;
   logic [AW-1:0]      wrPtr_q, wrPtr_d;
   logic [AW-1:0]      rdPtr_q, rdPtr_d;
   logic [AW:0]        count_q, count_d;
   logic [AW-1:0]      postLeft_q, postLeft_d;
   logic               triggered_q, triggered_d;
   logic [AW-1:0]      postClamped;
   logic               wrEn;
   logic               hit;
   logic               rdValid;
   logic               pop;
   logic [ENTRY_W-1:0] wrData;
   logic [ENTRY_W-1:0] ramRdData;

   assign hit         = ((bus.smp_instr & bus.trig_mask) == bus.trig_match);
   assign rdValid     = (state_q == FROZEN) && (count_q != '0);
   assign pop         = rdValid && bus.rd_ready;
   assign postClamped = clampPost(bus.post_count);

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   // The cycle counter runs whenever the block is out of reset. It is not
   // tied to the capture state, so the timestamp spacing shows how many core
   // cycles passed between the recorded samples.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
      end
   end

   assign wrData = {ts_q, bus.smp_instr, bus.smp_alu};
`else
   assign wrData = {bus.smp_instr, bus.smp_alu};
`endif

   // These are the capture state registers.
   // Reset returns the block to an empty IDLE buffer straight away, so stale
   // RAM contents can never reach rd_data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         postLeft_q  <= '0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         postLeft_q  <= postLeft_d;
         triggered_q <= triggered_d;
      end
   end

   // This is the next-state logic.
   // abort has top priority: it empties the buffer whatever else is going on.
   // While ARMED or POST, every sample is written into the ring. When the ring
   // is full, the oldest entry is dropped by moving the read pointer along,
   // so count stays at DEPTH.
   // The trigger is only recognised in ARMED, so later matches in POST do not
   // restart the window.
   // In FROZEN, each pop walks the read pointer forward. The final pop returns
   // the block to IDLE and leaves the sticky triggered flag set for the host.
   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      postLeft_d  = postLeft_q;
      triggered_d = triggered_q;
      wrEn        = 1'b0;

      if (bus.abort) begin
         state_d     = IDLE;
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         count_d     = '0;
         postLeft_d  = '0;
         triggered_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.arm) begin
                  state_d     = ARMED;
                  wrPtr_d     = '0;
                  rdPtr_d     = '0;
                  count_d     = '0;
                  postLeft_d  = '0;
                  triggered_d = 1'b0;
               end
            end
            ARMED, POST: begin
               if (bus.smp_valid) begin
                  wrEn    = 1'b1;
                  wrPtr_d = wrPtr_q + 1'b1;
                  if (count_q == FULL_COUNT) begin
                     rdPtr_d = rdPtr_q + 1'b1;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
                  if (state_q == ARMED) begin
                     if (hit) begin
                        triggered_d = 1'b1;
                        postLeft_d  = postClamped;
                        state_d     = (postClamped == '0) ? FROZEN : POST;
                     end
                  end else begin
                     postLeft_d = postLeft_q - 1'b1;
                     if (postLeft_q == AW'(1)) begin
                        state_d = FROZEN;
                     end
                  end
               end
            end
            FROZEN: begin
               if (pop) begin
                  rdPtr_d = rdPtr_q + 1'b1;
                  count_d = count_q - 1'b1;
                  if (count_q == ONE_COUNT) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (ENTRY_W)
   ) uRam (
      .clock   (clock),
      .we_i    (wrEn),
      .wAddr_i (wrPtr_q),
      .wData_i (wrData),
      .rAddr_i (rdPtr_q),
      .rData_o (ramRdData)
   );

   // rd_data is forced to zero whenever nothing is valid. This keeps
   // uninitialised or stale RAM words off the port.
   assign bus.rd_valid  = rdValid;
   assign bus.rd_data   = rdValid ? ramRdData : '0;
   assign bus.state     = state_q;
   assign bus.count     = count_q;
   assign bus.triggered = triggered_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_exec_trace_buffer
// This bench drives exec_trace_buffer through its interface.
// A queue-based reference model tracks what the trace window should hold.
// Directed scenarios cover the main cases, followed by a randomized run.
// Optional feature macro: TRACE_TIMESTAMP_EN. When defined, the model also
// stamps its entries with a cycle count.
// ---------------------------------------------------------------------------
module tb_exec_trace_buffer;
   import trace_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;

   exec_trace_buffer_if bus();

   exec_trace_buffer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   // The reference model: a queue holds the captured window, oldest first.
   int                 mState;
   logic [ENTRY_W-1:0] mq[$];
   bit                 mTrig;
   int                 mPostLeft;
`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]    tsModel = '0;
`endif

   logic [31:0] sampleInstr [128];

   function automatic logic [ENTRY_W-1:0] makeEntry(input logic [31:0] instr, input logic [31:0] alu);
`ifdef TRACE_TIMESTAMP_EN
      return {tsModel, instr, alu};
`else
      return {instr, alu};
`endif
   endfunction

   // Makes a random instruction. The opcode field is forced to ADDI (a match)
   // or to R-type (not a match).
   function automatic logic [31:0] randInstr(input bit match);
      logic [31:0] r;
      r = $urandom();
      r[31:26] = match ? 6'b001000 : 6'b000000;
      return r;
   endfunction

   task automatic modelClear();
      mState    = 0;
      mq.delete();
      mTrig     = 1'b0;
      mPostLeft = 0;
   endtask

   // Advances the model by one clock edge, using the inputs seen at that edge.
   task automatic modelEdge();
      if (bus.abort) begin
         modelClear();
      end else begin
         case (mState)
            0: begin
               if (bus.arm) begin
                  mState = 1;
                  mq.delete();
                  mTrig = 1'b0;
               end
            end
            1, 2: begin
               if (bus.smp_valid) begin
                  mq.push_back(makeEntry(bus.smp_instr, bus.smp_alu));
                  if (mq.size() > DEPTH) void'(mq.pop_front());
                  if (mState == 1) begin
                     if ((bus.smp_instr & bus.trig_mask) == bus.trig_match) begin
                        mTrig     = 1'b1;
                        mPostLeft = (int'(bus.post_count) > DEPTH - 1) ? DEPTH - 1 : int'(bus.post_count);
                        mState    = (mPostLeft == 0) ? 3 : 2;
                     end
                  end else begin
                     mPostLeft--;
                     if (mPostLeft == 0) mState = 3;
                  end
               end
            end
            default: begin
               if (mq.size() != 0 && bus.rd_ready) begin
                  void'(mq.pop_front());
                  if (mq.size() == 0) mState = 0;
               end
            end
         endcase
      end
`ifdef TRACE_TIMESTAMP_EN
      tsModel = tsModel + 1'b1;
`endif
   endtask

   task automatic checkOutput(input string tag);
      logic [ENTRY_W-1:0] expData;
      logic [AW:0]        expCount;
      expData  = (mState == 3 && mq.size() != 0) ? mq[0] : '0;
      expCount = (AW+1)'(mq.size());
      compared++;
      assert (bus.state === 2'(mState)) else begin
         mismatched++;
         $error("FAIL %s state: observed %0d required %0d", tag, bus.state, mState);
      end
      compared++;
      assert (bus.count === expCount) else begin
         mismatched++;
         $error("FAIL %s count: observed %0d required %0d", tag, bus.count, expCount);
      end
      compared++;
      assert (bus.rd_valid === (mState == 3 && mq.size() != 0)) else begin
         mismatched++;
         $error("FAIL %s rd_valid: observed %b required %b", tag, bus.rd_valid, (mState == 3 && mq.size() != 0));
      end
      compared++;
      assert (bus.triggered === mTrig) else begin
         mismatched++;
         $error("FAIL %s triggered: observed %b required %b", tag, bus.triggered, mTrig);
      end
      compared++;
      assert (bus.rd_data === expData) else begin
         mismatched++;
         $error("FAIL %s rd_data: observed %h required %h", tag, bus.rd_data, expData);
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, then advances the model at the edge and
   // checks every output a little after that edge.
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] alu,
                                input logic armI, input logic abortI, input logic readyI,
                                input string tag);
      bus.smp_valid = v;
      bus.smp_instr = instr;
      bus.smp_alu   = alu;
      bus.arm       = armI;
      bus.abort     = abortI;
      bus.rd_ready  = readyI;
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   task automatic doReset(input string tag);
      reset = 1'b1;
      #1;
      modelClear();
`ifdef TRACE_TIMESTAMP_EN
      tsModel = '0;
`endif
      checkOutput(tag);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      bus.smp_valid  = 1'b0;
      bus.smp_instr  = '0;
      bus.smp_alu    = '0;
      bus.arm        = 1'b0;
      bus.abort      = 1'b0;
      bus.rd_ready   = 1'b0;
      bus.trig_mask  = 32'hFC000000;
      bus.trig_match = 32'h20000000;
      bus.post_count = AW'(3);
      modelClear();

      // Power-on reset
      doReset("reset");

      // Reset while capturing must clear everything immediately.
      applyStimulus(0, 0, 0, 1, 0, 0, "armA");
      for (int i = 0; i < 5; i++) applyStimulus(1, randInstr(0), $urandom(), 0, 0, 0, "sampA");
      checkValue("armedCountA", 32'(bus.count), 32'd5);
      doReset("resetMidArmed");

      // Arm, ten non-matching samples, then abort. The abort arrives together
      // with a sample, and abort must win.
      applyStimulus(0, 0, 0, 1, 0, 0, "armB");
      for (int i = 0; i < 10; i++) applyStimulus(1, randInstr(0), $urandom(), 0, 0, 0, "sampB");
      applyStimulus(1, randInstr(1), $urandom(), 0, 1, 1, "abortB");
      checkValue("abortCountB", 32'(bus.count), 32'd0);
      applyStimulus(1, randInstr(0), $urandom(), 0, 0, 1, "idleB");

      // Trigger on the 5th of 12 samples with post_count=3. The buffer should
      // freeze after the 8th sample.
      bus.post_count = AW'(3);
      applyStimulus(0, 0, 0, 1, 0, 0, "armC");
      for (int i = 0; i < 12; i++) begin
         sampleInstr[i] = randInstr(i == 4);
         applyStimulus(1, sampleInstr[i], $urandom(), 0, 0, 0, "sampC");
         if (i == 7) begin
            checkValue("frozenStateC", 32'(bus.state), 32'd3);
            checkValue("frozenCountC", 32'(bus.count), 32'd8);
         end
      end
      for (int k = 0; k < 8; k++) begin
         checkValue("orderC", bus.rd_data[INSTR_LSB +: 32], sampleInstr[k]);
         applyStimulus(0, 0, 0, 0, 0, 1, "drainC");
      end
      checkValue("idleAfterC", 32'(bus.state), 32'd0);
      checkValue("stickyC", 32'(bus.triggered), 32'd1);

      // Ring wrap: 100 misses, then a trigger with post_count=0. The window
      // should hold samples 38..101.
      bus.post_count = AW'(0);
      applyStimulus(0, 0, 0, 1, 0, 0, "armD");
      for (int i = 0; i < 101; i++) begin
         sampleInstr[i] = randInstr(i == 100);
         applyStimulus(1, sampleInstr[i], $urandom(), 0, 0, 0, "sampD");
      end
      checkValue("fullCountD", 32'(bus.count), 32'd64);
      for (int k = 0; k < 64; k++) begin
         checkValue("orderD", bus.rd_data[INSTR_LSB +: 32], sampleInstr[37 + k]);
         applyStimulus(0, 0, 0, 0, 0, 1, "drainD");
      end

      // Stall while frozen: samples keep arriving and an arm is attempted,
      // but nothing may move.
      bus.post_count = AW'(2);
      applyStimulus(0, 0, 0, 1, 0, 0, "armE");
      for (int i = 0; i < 3; i++) applyStimulus(1, randInstr(1), $urandom(), 0, 0, 0, "sampE");
      for (int i = 0; i < 5; i++) applyStimulus(1, randInstr(1), $urandom(), (i == 2), 0, 0, "stallE");
      checkValue("stallCountE", 32'(bus.count), 32'd3);
      guard = 0;
      while (mState == 3 && guard < 50) begin
         applyStimulus(0, 0, 0, 0, 0, $urandom_range(0, 1), "drainE");
         guard++;
      end
      checkValue("drainBoundE", 32'(mState), 32'd0);

      // Randomized run: arm/abort/samples/pops in any mix
      for (int i = 0; i < 400; i++) begin
         bus.post_count = AW'($urandom_range(0, 5));
         applyStimulus($urandom_range(0, 1), randInstr($urandom_range(0, 7) == 0), $urandom(),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                       $urandom_range(0, 1), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
